mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width; only 32 is required to be supported.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request to begin an operation; sampled on rising clk.
REQ-005 op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 a  in  32  rs operand: multiplicand or dividend.
REQ-007 b  in  32  rt operand: multiplier or divisor.
REQ-008 busy  out  1  high while an operation is in progress.
REQ-009 done  out  1  one-cycle pulse when hi/lo carry a new result.
REQ-010 hi  out  32  HI result: product[63:32] or remainder.
REQ-011 lo  out  32  LO result: product[31:0] or quotient.
REQ-012 div_by_zero  out  1  high with done when a DIV/DIVU divisor was 0; low otherwise.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE; after reset the state is IDLE.
REQ-014 IDLE or DONE with start=1 SHALL capture op, a and b, clear the iteration counter, and go to CALC; with start=0, DONE goes to IDLE and IDLE stays in IDLE.
REQ-015 CALC SHALL run exactly WIDTH iterations using radix-2 shift-add (multiply) or restoring shift-subtract (divide), one iteration per cycle, then go to DONE.
REQ-016 Latency: if start is sampled at edge N, done SHALL be 1 in the cycle following edge N+WIDTH+1, which is 33 cycles for WIDTH=32.
REQ-017 busy SHALL be 1 exactly while in CALC; done SHALL be 1 exactly while in DONE.
REQ-018 start while busy=1 SHALL be ignored; changes on a, b or op after capture SHALL NOT affect the result.
REQ-019 hi and lo SHALL update only on the edge entering DONE, and SHALL hold their value until the next entry into DONE.
REQ-020 MULT/DIV (signed) SHALL compute on magnitudes of the two's-complement operands and apply the sign fix-up on the final CALC cycle.
REQ-021 Signed product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = sign of a; a zero result is never negated.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000, with no trap.
REQ-023 Divisor 0 (DIVU or DIV) SHALL give lo=0xFFFFFFFF, hi=a (captured value) and div_by_zero=1, with normal latency.
REQ-024 MULT/MULTU SHALL produce the exact 64-bit product as {hi,lo}.
REQ-025 For every other division, a = lo*b + hi SHALL hold with |hi| < |b|.

Reset
REQ-026 rst low SHALL immediately force: state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, and counter and internal registers to 0, regardless of clk.
REQ-027 A reset during CALC SHALL abort the operation; no done pulse and no hi/lo update SHALL follow.
REQ-028 On the first edge after rst rises, start SHALL be accepted normally.

Structure
REQ-029 Shared package mdu_pkg SHALL hold the op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV), the state encodings and the default WIDTH.
REQ-030 The block SHALL be a single module with no sub-module; the accumulator, the shift register and the FSM all reside in mult_div_unit.
REQ-031 The datapath SHALL connect a to the rs read port and b to the rt read port, and SHALL feed hi/lo into the HI/LO write-back mux, with done acting as the HI/LO write enable.

Verification
REQ-032 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 (-15).
REQ-034 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=7 -> lo=14, hi=2.
REQ-035 DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1 during the done cycle.
REQ-036 Start MULTU 6x7, then pulse start with new operands at cycle 5 and assert rst low at cycle 10 -> the cycle-5 start is ignored; at cycle 10 busy=0, hi=lo=0, and no done pulse follows.
REQ-037 Start DIVU 9/3, then assert start again with MULTU 4x4 in the done cycle -> first result lo=3, hi=0; the second operation is accepted back-to-back and gives lo=16, hi=0 33 cycles later.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation and FSM state
// encodings, default operand width and a sign helper.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_CALC  = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    // Magnitude of a two's-complement value when sgn is set, raw value otherwise.
    function automatic logic [MDU_WIDTH-1:0] mag_of(input logic [MDU_WIDTH-1:0] v,
                                                    input logic                 sgn);
        if (sgn && v[MDU_WIDTH-1]) begin
            mag_of = {MDU_WIDTH{1'b0}} - v;
        end else begin
            mag_of = v;
        end
    endfunction

    // Negate v when neg is set; zero is returned unchanged.
    function automatic logic [MDU_WIDTH-1:0] neg_fix(input logic [MDU_WIDTH-1:0] v,
                                                     input logic                 neg);
        if (neg && (v != {MDU_WIDTH{1'b0}})) begin
            neg_fix = {MDU_WIDTH{1'b0}} - v;
        end else begin
            neg_fix = v;
        end
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one setup cycle plus WIDTH iterations, results latched into HI/LO.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               is_div_s;
    logic               is_signed_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH-1:0]   mul_hi_s, mul_lo_s;
    logic [WIDTH:0]     div_shift_s, div_diff_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   div_rem_s, div_quo_s;
    logic [2*WIDTH-1:0] prod_s, prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s, rem_fix_s;

    assign is_div_s    = (op_q == OP_DIVU) || (op_q == OP_DIV);
    assign is_signed_s = (op_q == OP_MULT) || (op_q == OP_DIV);

    // Multiply step: acc holds the upper product half, sh shifts the multiplier out.
    assign mul_sum_s = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    assign mul_hi_s  = mul_sum_s[WIDTH:1];
    assign mul_lo_s  = {mul_sum_s[0], sh_q[WIDTH-1:1]};

    // Divide step: acc is the partial remainder, sh shifts dividend out and quotient in.
    assign div_shift_s = {acc_q, sh_q[WIDTH-1]};
    assign div_diff_s  = div_shift_s - {1'b0, opb_q};
    assign div_ge_s    = ~div_diff_s[WIDTH];
    assign div_rem_s   = div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
    assign div_quo_s   = {sh_q[WIDTH-2:0], div_ge_s};

    assign prod_s     = {mul_hi_s, mul_lo_s};
    assign prod_fix_s = (neg_q && (prod_s != {(2*WIDTH){1'b0}}))
                        ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;
    // A zero divisor leaves |a| as remainder, so the remainder sign fix restores a.
    assign quo_fix_s  = dz_q ? {WIDTH{1'b1}} : neg_fix(div_quo_s, neg_q);
    assign rem_fix_s  = neg_fix(div_rem_s, rneg_q);

    // Next-state logic for the FSM, the iteration datapath and the result registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_CALC;
                    cnt_d   = {CW{1'b0}};
                    op_d    = op;
                    acc_d   = {WIDTH{1'b0}};
                    sh_d    = a;
                    opb_d   = b;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == {CW{1'b0}}) begin
                    sh_d   = mag_of(sh_q, is_signed_s);
                    opb_d  = mag_of(opb_q, is_signed_s);
                    neg_d  = is_signed_s & (sh_q[WIDTH-1] ^ opb_q[WIDTH-1]);
                    rneg_d = is_signed_s & sh_q[WIDTH-1];
                    dz_d   = is_div_s & (opb_q == {WIDTH{1'b0}});
                    acc_d  = {WIDTH{1'b0}};
                end else begin
                    if (is_div_s) begin
                        acc_d = div_rem_s;
                        sh_d  = div_quo_s;
                    end else begin
                        acc_d = mul_hi_s;
                        sh_d  = mul_lo_s;
                    end
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                        dbz_d   = dz_q;
                        if (is_div_s) begin
                            hi_d = rem_fix_s;
                            lo_d = quo_fix_s;
                        end else begin
                            hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
                            lo_d = prod_fix_s[WIDTH-1:0];
                        end
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_CALC);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            op_q    <= 2'b00;
            acc_q   <= {WIDTH{1'b0}};
            sh_q    <= {WIDTH{1'b0}};
            opb_q   <= {WIDTH{1'b0}};
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/div_by_zero and done
// timing are queued at start and compared when done pulses.
module tb_mult_div_unit;
    import mdu_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          edge_n;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [63:0] p;
        e.dz = 1'b0;
        e.edge_n = 0;
        e.hi = 32'd0;
        e.lo = 32'd0;
        if (o == OP_MULTU) begin
            p = {32'd0, x} * {32'd0, y};
            {e.hi, e.lo} = p;
        end else if (o == OP_MULT) begin
            p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
            {e.hi, e.lo} = p;
        end else if (y == 32'd0) begin
            e.lo = 32'hFFFF_FFFF;
            e.hi = x;
            e.dz = 1'b1;
        end else if (o == OP_DIV && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000;
            e.hi = 32'd0;
        end else if (o == OP_DIV) begin
            e.lo = $signed(x) / $signed(y);
            e.hi = $signed(x) % $signed(y);
        end else begin
            e.lo = x / y;
            e.hi = x % y;
        end
        return e;
    endfunction

    // Result monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("hi", {32'd0, hi}, {32'd0, e.hi});
                check_eq("lo", {32'd0, lo}, {32'd0, e.lo});
                check_eq("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dz});
                check_eq("done_latency", 64'(cyc), 64'(e.edge_n));
                check_eq("busy_in_done", {63'd0, busy}, 64'd0);
            end
        end
    end

    // Drive a start at the current negedge; it is sampled on the next posedge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        e = model(o, x, y);
        e.edge_n = cyc + 1 + 33;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            check_eq("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit disturb);
        @(negedge clk);
        issue(o, x, y);
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        a     = $urandom;
        b     = $urandom;
        check_eq("busy_in_calc", {63'd0, busy}, 64'd1);
        if (disturb) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        int n;
        rst   = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_hi", {32'd0, hi}, 64'd0);
        check_eq("rst_lo", {32'd0, lo}, 64'd0);
        check_eq("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        rst = 1'b1;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,         1'b1);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0);
        run_op(OP_DIVU,  32'd100,       32'd7,         1'b1);
        run_op(OP_DIVU,  32'd100,       32'd0,         1'b0);
        run_op(OP_DIV,   32'hFFFF_FF9C, 32'd0,         1'b0);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(OP_MULT,  32'd0,         32'hFFFF_FFFF, 1'b0);
        run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 1'b0);
        for (int i = 0; i < 12; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 4 == 3) ? 32'($urandom_range(0, 15)) : $urandom;
            run_op(ro, ra, rb, (i % 3) == 0);
        end

        // Back-to-back: second start asserted during the done cycle.
        @(negedge clk);
        issue(OP_DIVU, 32'd9, 32'd3);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("b2b_first_done", {63'd0, done}, 64'd1);
        issue(OP_MULTU, 32'd4, 32'd4);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Abort: ignored restart at cycle 5, reset at cycle 10, no done afterwards.
        @(negedge clk);
        issue(OP_MULTU, 32'd6, 32'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd1000;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("abort_busy", {63'd0, busy}, 64'd0);
        check_eq("abort_done", {63'd0, done}, 64'd0);
        check_eq("abort_hi", {32'd0, hi}, 64'd0);
        check_eq("abort_lo", {32'd0, lo}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (45) @(negedge clk);
        check_eq("abort_hi_hold", {32'd0, hi}, 64'd0);

        // Start on the very first edge after reset release.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
